// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a divide by zero.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // FIX is only visited when signed division is built in.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FIN  = 2'd3
    } div_state_t;

endpackage

// File: rtl/add_32.sv
// Plain ripple-style adder with carry in/out, shared datapath building block.
// Latency: combinational.
// Backpressure: none.
module add_32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Full-width add with the carry out taken from the extra top bit.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract divisor, restore on borrow.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] diff;
    logic             carry;
    logic             fits;

    assign r_shift = {r, q[WIDTH-1]};

    // Subtraction as a + ~b + 1; carry out of the low WIDTH bits means no borrow there.
    add_32 #(.WIDTH(WIDTH)) u_sub (
        .a    (r_shift[WIDTH-1:0]),
        .b    (~divisor),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    // The WIDTH+1-bit difference is non-negative when the shifted remainder's top bit
    // is set (it then exceeds any divisor) or the low subtraction produced no borrow.
    always_comb begin
        fits   = r_shift[WIDTH] | carry;
        r_next = fits ? diff : r_shift[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_32_seq.sv
// Multi-cycle restoring divider (quotient -> LO, remainder -> HI), one quotient bit per clock.
// Latency: WIDTH+1 clocks start-to-done (WIDTH+2 with DIV_SIGNED_EN), 1 clock for divide by zero.
// Backpressure: start is ignored while busy; optional macro DIV_SIGNED_EN enables two's complement operands.
module div_32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvsr;
    logic             dz_pend;
    logic [WIDTH-1:0] r_nxt;
    logic [WIDTH-1:0] q_nxt;

`ifdef DIV_SIGNED_EN
    logic sign_q;
    logic sign_r;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r       (r_reg),
        .q       (q_reg),
        .divisor (dvsr),
        .r_next  (r_nxt),
        .q_next  (q_nxt)
    );

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            dvsr        <= '0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    // Publish the finished result; the done pulse lands in the next cycle.
                    if (state == FIN) begin
                        quotient    <= q_reg;
                        remainder   <= r_reg;
                        div_by_zero <= dz_pend;
                        done        <= 1'b1;
                    end else if (start) begin
                        div_by_zero <= 1'b0;
                    end
                    if (start) begin
                        if (divisor == '0) begin
                            // Divide by zero skips the iterations entirely.
                            q_reg   <= DIV0_QUOTIENT;
                            r_reg   <= dividend;
                            dz_pend <= 1'b1;
                            busy    <= 1'b0;
                            state   <= FIN;
                        end else begin
                            r_reg   <= '0;
`ifdef DIV_SIGNED_EN
                            q_reg   <= mag(dividend);
                            dvsr    <= mag(divisor);
                            sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            sign_r  <= dividend[WIDTH-1];
`else
                            q_reg   <= dividend;
                            dvsr    <= divisor;
`endif
                            cnt     <= CNT_W'(WIDTH - 1);
                            dz_pend <= 1'b0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // A start accepted in FIN leaves the old flag visible for its done pulse; drop it now.
                    div_by_zero <= 1'b0;
                    r_reg       <= r_nxt;
                    q_reg       <= q_nxt;
                    cnt         <= cnt - 1'b1;
                    if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
                        state <= FIX;
`else
                        busy  <= 1'b0;
                        state <= FIN;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    // Truncating division: quotient negative on sign mismatch, remainder follows dividend.
                    div_by_zero <= 1'b0;
                    q_reg       <= sign_q ? (~q_reg + 1'b1) : q_reg;
                    r_reg       <= sign_r ? (~r_reg + 1'b1) : r_reg;
                    busy        <= 1'b0;
                    state       <= FIN;
                end
`endif
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
